// File: rtl/uart_rx_core_if.sv
// FIFO-facing and line-facing signals of the UART receive core, bundled.
// master: the receive core. slave: whatever sits around it (serial source,
// RX FIFO, error-clearing logic).
interface uart_rx_core_if;
   logic       i_Serial;
   logic       i_Full;
   logic       i_ClearErrors;
   logic [7:0] o_Data;
   logic       o_WriteRequest;
   logic       o_Busy;
   logic       o_FrameError;
   logic       o_Overrun;

   modport master (
      input  i_Serial,
      input  i_Full,
      input  i_ClearErrors,
      output o_Data,
      output o_WriteRequest,
      output o_Busy,
      output o_FrameError,
      output o_Overrun
   );

   modport slave (
      output i_Serial,
      output i_Full,
      output i_ClearErrors,
      input  o_Data,
      input  o_WriteRequest,
      input  o_Busy,
      input  o_FrameError,
      input  o_Overrun
   );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding an RX FIFO through a one-cycle write strobe.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | counting to the start-bit midpoint, rejecting glitches
// S_DATA  | sampling 8 data bits, one per bit period, LSB first
// S_STOP  | waiting one bit period, then sampling the stop bit
// S_BREAK | stop bit was low; waiting for the line to return high
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clock,
   input  logic           reset,
   uart_rx_core_if.master bus
);

   localparam logic [15:0] CNT_HALF = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] CNT_BIT  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic        sync1_q, rx_s;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        wr_q, fe_q, ov_q;

   logic        sample_data;
   logic        stop_good;
   logic        stop_drop;
   logic        stop_bad;

   // two-flop synchronizer; resets to the idle (high) line level so a reset
   // never looks like a falling edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_q <= bus.i_Serial;
         rx_s    <= sync1_q;
      end
   end

   // state register with bit-period counter and bit index
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // next-state logic and per-cycle sampling events
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sample_data = 1'b0;
      stop_good   = 1'b0;
      stop_drop   = 1'b0;
      stop_bad    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_BIT) begin
               cnt_d       = '0;
               sample_data = 1'b1;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_BIT) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
                  // i_Full only matters here, on the stop-sample cycle
                  if (bus.i_Full) begin
                     stop_drop = 1'b1;
                  end else begin
                     stop_good = 1'b1;
                  end
               end else begin
                  state_d  = S_BREAK;
                  stop_bad = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // shift register, output byte, write strobe and sticky error flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         if (sample_data) begin
            shift_q[idx_q] <= rx_s;
         end
         // o_Data only moves on a good byte, so it stays valid for the FIFO's
         // deferred capture until the next good frame
         if (stop_good) begin
            data_q <= shift_q;
         end
         wr_q <= stop_good;
         // a set event on the same cycle as a clear wins
         if (stop_bad) begin
            fe_q <= 1'b1;
         end else if (bus.i_ClearErrors) begin
            fe_q <= 1'b0;
         end
         if (stop_drop) begin
            ov_q <= 1'b1;
         end else if (bus.i_ClearErrors) begin
            ov_q <= 1'b0;
         end
      end
   end

   // outputs
   always_comb begin
      bus.o_Data         = data_q;
      bus.o_WriteRequest = wr_q;
      bus.o_Busy         = (state_q != S_IDLE);
      bus.o_FrameError   = fe_q;
      bus.o_Overrun      = ov_q;
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLKS_PER_BIT=16. Stimulus drives whole frames on
// the serial line; each frame schedules what the receiver must show and when,
// as timestamped events computed from the frame timing. One compare process
// checks every output on every cycle against that event-driven model.
module tb_uart_rx_core;

   localparam int CPB = 16;
   // cycles from the first edge that sees a falling start edge to the stop
   // sample: 2 sync flops, 1 idle detect, half period, 9 full periods
   localparam int STOP_LAT = 2 + 1 + 1 + (CPB - 1) / 2 + 9 * CPB;
   localparam int FRAME    = 10 * CPB;
   localparam int FIFO_DEPTH = 4;

   localparam int EV_WR   = 0;
   localparam int EV_FE   = 1;
   localparam int EV_OV   = 2;
   localparam int EV_CLR  = 3;
   localparam int EV_BON  = 4;
   localparam int EV_BOFF = 5;

   typedef struct {
      int         c;
      int         k;
      logic [7:0] v;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;

   uart_rx_core_if bus ();

   uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   ev_t        ev_q[$];
   logic [7:0] fifo_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         wr_seen = 0;

   logic [7:0] m_data;
   logic       m_busy, m_fe, m_ov, exp_wr;

   function automatic void push_ev(input int c, input int k, input logic [7:0] v);
      ev_t e;
      e.c = c;
      e.k = k;
      e.v = v;
      ev_q.push_back(e);
   endfunction

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // per-cycle model update and compare
   initial begin : compare_proc
      logic set_fe, set_ov, clr;
      forever begin
         @(negedge clock);
         #1;
         if (!reset) begin
            m_data = 8'h00;
            m_busy = 1'b0;
            m_fe   = 1'b0;
            m_ov   = 1'b0;
            exp_wr = 1'b0;
            ev_q.delete();
         end else begin
            exp_wr = 1'b0;
            set_fe = 1'b0;
            set_ov = 1'b0;
            clr    = 1'b0;
            for (int i = ev_q.size() - 1; i >= 0; i--) begin
               if (ev_q[i].c == cyc) begin
                  case (ev_q[i].k)
                     EV_WR:   begin exp_wr = 1'b1; m_data = ev_q[i].v; end
                     EV_FE:   set_fe = 1'b1;
                     EV_OV:   set_ov = 1'b1;
                     EV_CLR:  clr = 1'b1;
                     EV_BON:  m_busy = 1'b1;
                     EV_BOFF: m_busy = 1'b0;
                     default: ;
                  endcase
                  ev_q.delete(i);
               end
            end
            if (set_fe) m_fe = 1'b1; else if (clr) m_fe = 1'b0;
            if (set_ov) m_ov = 1'b1; else if (clr) m_ov = 1'b0;
         end
         if (bus.o_WriteRequest === 1'b1) begin
            wr_seen++;
            fifo_q.push_back(bus.o_Data);
         end
         n_cmp++;
         if (bus.o_WriteRequest !== exp_wr || bus.o_Data !== m_data ||
             bus.o_Busy !== m_busy || bus.o_FrameError !== m_fe || bus.o_Overrun !== m_ov) begin
            n_bad++;
            $display("FAIL cycle %0d outputs (got/want): wr %b/%b data %h/%h busy %b/%b fe %b/%b ov %b/%b",
                     cyc, bus.o_WriteRequest, exp_wr, bus.o_Data, m_data, bus.o_Busy, m_busy,
                     bus.o_FrameError, m_fe, bus.o_Overrun, m_ov);
         end
      end
   end

   task automatic drive_clear(input bit rnd, input bit force_it);
      bus.i_ClearErrors = force_it || (rnd && ($urandom_range(0, 15) == 0));
      if (bus.i_ClearErrors) push_ev(cyc + 1, EV_CLR, 8'h00);
   endtask

   task automatic idle(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         bus.i_Serial = 1'b1;
         bus.i_Full   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         drive_clear(rnd, 1'b0);
         @(negedge clock);
      end
   endtask

   // one frame; bit b occupies cycles [16b, 16b+16) from the start edge
   task automatic send_frame(input logic [7:0] data, input bit stop, input bit full_stop,
                             input bit rnd, input bit clr_stop, input int abort_k,
                             input int hold, input int gap);
      int p;
      int h;
      logic [9:0] bits;
      p    = cyc;
      bits = {stop, data, 1'b0};
      push_ev(p + 3, EV_BON, 8'h00);
      if (abort_k >= FRAME) begin
         if (!stop) begin
            push_ev(p + STOP_LAT, EV_FE, 8'h00);
         end else if (full_stop) begin
            push_ev(p + STOP_LAT, EV_OV, 8'h00);
            push_ev(p + STOP_LAT, EV_BOFF, 8'h00);
         end else begin
            push_ev(p + STOP_LAT, EV_WR, data);
            push_ev(p + STOP_LAT, EV_BOFF, 8'h00);
         end
      end
      for (int k = 0; k < FRAME; k++) begin
         if (k == abort_k) return;
         bus.i_Serial = bits[k / CPB];
         if (k == STOP_LAT - 1) bus.i_Full = full_stop;
         else bus.i_Full = rnd ? 1'($urandom_range(0, 1)) : full_stop;
         drive_clear(rnd, clr_stop && (k == STOP_LAT - 1));
         @(negedge clock);
      end
      if (!stop) begin
         for (int i = 0; i < hold; i++) begin
            bus.i_Serial = 1'b0;
            bus.i_Full   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_clear(rnd, 1'b0);
            @(negedge clock);
         end
         h = cyc;
         push_ev(h + 3, EV_BOFF, 8'h00);
         idle((gap < 2) ? 2 : gap, rnd);
      end else begin
         idle(gap, rnd);
      end
   endtask

   // low pulse shorter than half a bit period must be rejected
   task automatic glitch(input int len);
      int p;
      p = cyc;
      push_ev(p + 3, EV_BON, 8'h00);
      push_ev(p + 3 + 1 + (CPB - 1) / 2, EV_BOFF, 8'h00);
      for (int i = 0; i < CPB; i++) begin
         bus.i_Serial = (i < len) ? 1'b0 : 1'b1;
         bus.i_Full   = 1'b0;
         bus.i_ClearErrors = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic clear_pulse();
      drive_clear(1'b0, 1'b1);
      @(negedge clock);
      bus.i_ClearErrors = 1'b0;
      @(negedge clock);
   endtask

   initial begin : stim
      int base;
      int accepted;
      logic full;
      bus.i_Serial      = 1'b1;
      bus.i_Full        = 1'b0;
      bus.i_ClearErrors = 1'b0;
      reset             = 1'b0;
      repeat (3) @(negedge clock);
      #2;
      pin("reset_data", 32'(bus.o_Data), 32'h00);
      pin("reset_busy", 32'(bus.o_Busy), 32'h0);
      pin("reset_wr", 32'(bus.o_WriteRequest), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      idle(5, 1'b0);

      // two frames back to back
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, FRAME, 0, 0);
      send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, FRAME, 0, 4);
      #2;
      pin("b2b_data", 32'(bus.o_Data), 32'hA3);
      pin("b2b_model_data", 32'(m_data), 32'hA3);
      pin("b2b_writes", 32'(wr_seen), 32'd2);
      pin("b2b_flags", 32'({bus.o_FrameError, bus.o_Overrun}), 32'h0);

      glitch(5);
      idle(4, 1'b0);
      #2;
      pin("glitch_busy", 32'(bus.o_Busy), 32'h0);
      pin("glitch_writes", 32'(wr_seen), 32'd2);

      // stop bit low, line held low afterwards, then a normal frame
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, FRAME, 40, 5);
      #2;
      pin("fe_flag", 32'(bus.o_FrameError), 32'h1);
      pin("fe_data_kept", 32'(bus.o_Data), 32'hA3);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, FRAME, 0, 3);
      #2;
      pin("after_fe_data", 32'(bus.o_Data), 32'h81);

      // overrun while full, then clear both flags
      send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, FRAME, 0, 3);
      #2;
      pin("ov_flag", 32'(bus.o_Overrun), 32'h1);
      pin("ov_data_kept", 32'(bus.o_Data), 32'h81);
      clear_pulse();
      #2;
      pin("ov_cleared", 32'(bus.o_Overrun), 32'h0);
      pin("fe_cleared", 32'(bus.o_FrameError), 32'h0);

      // overrun set on the same cycle as a clear: set wins
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, FRAME, 0, 3);
      #2;
      pin("set_beats_clear", 32'(bus.o_Overrun), 32'h1);
      clear_pulse();

      // reset in the middle of data bit 4 of 0xF0
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 5 * CPB + 8, 0, 0);
      reset = 1'b0;
      bus.i_Serial = 1'b1;
      #2;
      pin("midreset_busy", 32'(bus.o_Busy), 32'h0);
      pin("midreset_data", 32'(bus.o_Data), 32'h00);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      idle(3, 1'b0);
      base = wr_seen;
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, FRAME, 0, 3);
      #2;
      pin("post_reset_data", 32'(bus.o_Data), 32'h12);
      pin("post_reset_writes", 32'(wr_seen - base), 32'd1);

      // 9 bytes into a 4-deep FIFO with reads stalled
      fifo_q.delete();
      accepted = 0;
      for (int b = 1; b <= 9; b++) begin
         full = (accepted >= FIFO_DEPTH);
         send_frame(8'(b), 1'b1, full, 1'b0, 1'b0, FRAME, 0, 0);
         if (!full) accepted++;
         if (b == 4) begin #2; pin("fifo_no_ov_yet", 32'(bus.o_Overrun), 32'h0); end
         if (b == 5) begin #2; pin("fifo_first_drop_ov", 32'(bus.o_Overrun), 32'h1); end
      end
      idle(3, 1'b0);
      #2;
      pin("fifo_count", 32'(fifo_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         pin("fifo_byte", (i < fifo_q.size()) ? 32'(fifo_q[i]) : 32'hFFFF, 32'(i + 1));
      clear_pulse();

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) glitch($urandom_range(1, 8));
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                    1'b1, ($urandom_range(0, 3) == 0), FRAME,
                    $urandom_range(0, 30), $urandom_range(0, 10));
      end
      idle(20, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit period (legal range 8..65535).
REQ-002 SHALL provide port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port i_Serial  input  1  asynchronous RX line, idle high, 8N1, LSB first.
REQ-005 SHALL provide port i_Full  input  1  downstream RX FIFO full flag.
REQ-006 SHALL provide port i_ClearErrors  input  1  synchronous clear of sticky error flags.
REQ-007 SHALL provide port o_Data  output  8  last good received byte, feeds FIFO i_Data.
REQ-008 SHALL provide port o_WriteRequest  output  1  one-cycle write strobe to FIFO i_WriteRequest.
REQ-009 SHALL provide port o_Busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL provide port o_FrameError  output  1  sticky: stop bit sampled low.
REQ-011 SHALL provide port o_Overrun  output  1  sticky: good byte dropped because i_Full was high.

Function
REQ-012 SHALL pass i_Serial through a two-flop synchronizer, reset value 1; all decisions below use the synchronized line (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK, using a bit-period counter of 16 bits and a 3-bit bit index.
REQ-014 IDLE: on rx_s==0 SHALL go to START and clear the counter.
REQ-015 START: SHALL count to (CLKS_PER_BIT-1)/2 (integer division); at that count, rx_s==0 -> DATA with bit index 0, rx_s==1 -> IDLE (glitch rejected, no outputs change).
REQ-016 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles from the start-bit midpoint into bit[index], LSB first; after bit 7 go to STOP.
REQ-017 STOP: SHALL sample rx_s CLKS_PER_BIT cycles after the bit-7 sample.
REQ-018 Stop sample 1 and i_Full==0: SHALL load o_Data and pulse o_WriteRequest high for exactly one cycle, the cycle after the stop sample, then return to IDLE.
REQ-019 Stop sample 1 and i_Full==1: SHALL NOT pulse o_WriteRequest, SHALL leave o_Data unchanged, SHALL set o_Overrun, return to IDLE.
REQ-020 Stop sample 0: SHALL set o_FrameError, SHALL NOT write, go to BREAK; BREAK SHALL wait until rx_s==1, then IDLE.
REQ-021 o_Data SHALL stay stable from the write strobe until the next good byte (>= 9 bit periods), satisfying the FIFO's deferred data capture.
REQ-022 o_WriteRequest SHALL never be high on two consecutive cycles.
REQ-023 i_Full SHALL be evaluated only in the stop-sample cycle.
REQ-024 i_ClearErrors SHALL clear both sticky flags; if a set event coincides with the clear, the set SHALL win.
REQ-025 A new start bit SHALL be accepted on the first cycle back in IDLE (back-to-back frames, no idle gap required).

Reset
REQ-026 reset low SHALL asynchronously force: FSM IDLE, counter 0, bit index 0, synchronizer flops 1, o_Data 0x00, o_WriteRequest 0, o_Busy 0, o_FrameError 0, o_Overrun 0.
REQ-027 reset asserted mid-frame SHALL discard the partial byte with no write strobe; after release, reception SHALL resume only on a fresh falling edge of rx_s.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0x55 then 0xA3 back-to-back, i_Full=0 -> two single-cycle o_WriteRequest pulses, o_Data 0x55 then 0xA3, no error flags.
REQ-029 Drive i_Serial low for 5 cycles in idle -> o_Busy high <= 8 cycles, returns to IDLE, no write, no flags.
REQ-030 Send 0x3C with stop bit 0, hold line low 40 cycles -> o_FrameError=1, no write, o_Busy high until line returns high; following 0x81 received normally.
REQ-031 Send 0x7E with i_Full=1 -> no write, o_Data keeps previous value, o_Overrun=1; pulse i_ClearErrors -> o_Overrun=0.
REQ-032 Assert reset during bit 4 of 0xF0 -> all outputs at reset values immediately; after release, 0x12 is received correctly and 0xF0 is never written.
REQ-033 Connect to the RX FIFO, send 9 bytes 0x01..0x09 with reads stalled -> bytes land in order until FIFO full, then o_Overrun=1 for the first dropped byte.
